// File: rtl/shiftreg_cmd_sequencer_pkg.sv
// Shared encodings for the shift-register command sequencer: sel codes
// (identical to the shift register's own sel decode) and FSM states.
package shiftreg_cmd_sequencer_pkg;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  // Command opcodes share the sel encoding; 00 means nop on the command side.
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LEFT  = 2'b01;
  localparam logic [1:0] OP_RIGHT = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // True for the two opcodes that expand into shift cycles.
  function automatic logic is_shift_op(input logic [1:0] op);
    return (op == OP_LEFT) || (op == OP_RIGHT);
  endfunction

endpackage

// File: rtl/shiftreg_cmd_sequencer_counter.sv
// Down counter for the SHIFT phase: parallel load, saturating decrement
// (never wraps below zero), and a zero flag the FSM uses to exit SHIFT.
module shiftreg_cmd_sequencer_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             sync_reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/shiftreg_cmd_sequencer.sv
// Command sequencer for the universal shift register. Each accepted command
// expands into LOAD (1 cycle), SHIFT (count cycles) or nothing, always
// followed by a single DONE cycle that pulses done.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE and depends on the
// state register alone, so cmd_valid may stay asserted across commands and
// cmd_* are ignored whenever cmd_ready is low.
module shiftreg_cmd_sequencer
  import shiftreg_cmd_sequencer_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             sync_reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  output logic [1:0]       sr_sel,
  output logic [WIDTH-1:0] sr_in,
  output logic             sr_rightshift,
  output logic             sr_leftshift,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  state_t           state, state_next;
  logic [1:0]       op_q;
  logic             fill_q;
  logic [WIDTH-1:0] data_q;
  logic             cap_en;

  logic [1:0]       sel_next;
  logic [WIDTH-1:0] in_next;
  logic             fill_next;
  logic             busy_next;
  logic             done_next;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;
  logic             accept;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign state_dbg = state;

  // Shift cycle counter: holds the remaining shifts after the current one.
  shiftreg_cmd_sequencer_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk         (clk),
    .sync_reset_n(sync_reset_n),
    .load        (cnt_load),
    .load_value  (cmd_count - {{(CNT_W-1){1'b0}}, 1'b1}),
    .dec         (cnt_dec),
    .count       (cnt_value),
    .zero        (cnt_zero)
  );

  // Next state plus next values of every registered output. Outputs are
  // computed for the state being entered so they line up with it.
  always_comb begin
    state_next = state;
    sel_next   = SEL_HOLD;
    in_next    = sr_in;
    fill_next  = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cap_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cap_en    = 1'b1;
          busy_next = 1'b1;
          if (cmd_op == OP_LOAD) begin
            state_next = ST_LOAD;
            sel_next   = SEL_LOAD;
            in_next    = cmd_data;
          end else if (is_shift_op(cmd_op) && (cmd_count != '0)) begin
            state_next = ST_SHIFT;
            sel_next   = cmd_op;
            fill_next  = cmd_fill;
            cnt_load   = 1'b1;
          end else begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_next = ST_DONE;
        busy_next  = 1'b1;
        done_next  = 1'b1;
      end
      ST_SHIFT: begin
        busy_next = 1'b1;
        if (cnt_zero) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else begin
          cnt_dec   = 1'b1;
          sel_next  = op_q;
          fill_next = fill_q;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register and registered outputs; reset aborts any command silently.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      state         <= ST_IDLE;
      sr_sel        <= SEL_HOLD;
      sr_in         <= '0;
      sr_rightshift <= 1'b0;
      sr_leftshift  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_next;
      sr_sel        <= sel_next;
      sr_in         <= in_next;
      sr_rightshift <= fill_next;
      sr_leftshift  <= fill_next;
      busy          <= busy_next;
      done          <= done_next;
    end
  end

  // Command capture: op and fill are replayed on every SHIFT cycle.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      op_q   <= OP_NOP;
      fill_q <= 1'b0;
      data_q <= '0;
    end else if (cap_en) begin
      op_q   <= cmd_op;
      fill_q <= cmd_fill;
      data_q <= cmd_data;
    end
  end

  // data_q is kept for debug visibility of the last accepted load value.
  logic unused_ok;
  assign unused_ok = ^{data_q, cnt_value};

endmodule
